// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the regfile_sb register file.
//   - default index / data widths
//   - is_zero_reg(): true when an index names the hardwired-zero register
//   - busy_delta():  net change of the busy population for one clock edge
package regfile_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 64;

    // Index 0 is only special when the hardwired-zero feature is enabled.
    function automatic logic is_zero_reg(input logic zero_en, input logic [31:0] idx);
        return zero_en && (idx == 32'd0);
    endfunction

    // +1 when some busy bit goes 0->1, -1 when some bit goes 1->0, else 0.
    function automatic logic signed [1:0] busy_delta(input logic inc, input logic dec);
        logic signed [1:0] d;
        d = 2'sd0;
        if (inc && !dec) begin
            d = 2'sd1;
        end else if (dec && !inc) begin
            d = -2'sd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy tracking for regfile_sb.
//   clk, rst_n            clock, asynchronous active-low reset
//   wen, waddr            writeback (frees the destination's busy bit)
//   raddr                 packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rbusy                 per-port "operand still in flight"
//   issue_valid, issue_rd reservation request from decode
//   issue_ready           reservation accepted (independent of issue_valid)
//   flush                 drop every reservation at the next edge
//   busy_cnt              number of reserved registers
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NREAD      = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD-1:0]            rbusy,
    input  logic                        issue_valid,
    input  logic [ADDR_WIDTH-1:0]       issue_rd,
    output logic                        issue_ready,
    input  logic                        flush,
    output logic [ADDR_WIDTH:0]         busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DEPTH-1:0]  r_busy;
    logic [CW-1:0]     r_busy_cnt;

    logic              w_wb_frees;
    logic              w_issue_fire;
    logic              w_set;
    logic              w_clr;
    logic              w_inc;
    logic              w_dec;
    logic signed [1:0] w_delta;

    // A writeback to the requested destination frees it this very cycle.
    assign w_wb_frees   = wen && (waddr == issue_rd);
    assign issue_ready  = !flush && (!r_busy[issue_rd] || w_wb_frees ||
                                     is_zero_reg(ZERO_REG, 32'(issue_rd)));
    assign w_issue_fire = issue_valid && issue_ready;
    assign w_set        = w_issue_fire && !is_zero_reg(ZERO_REG, 32'(issue_rd));
    assign w_clr        = wen && r_busy[waddr];

    // Count only real bit transitions: a writeback and a new reservation on
    // the same register leave it busy, so the count does not move.
    assign w_inc   = w_set && !r_busy[issue_rd];
    assign w_dec   = w_clr && !(w_set && (waddr == issue_rd));
    assign w_delta = busy_delta(w_inc, w_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else if (flush) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (wen) begin
                r_busy[waddr] <= 1'b0;
            end
            // Later assignment wins when both target the same index.
            if (w_set) begin
                r_busy[issue_rd] <= 1'b1;
            end
            r_busy_cnt <= r_busy_cnt + {{(CW-2){w_delta[1]}}, w_delta};
        end
    end

    assign busy_cnt = r_busy_cnt;

    for (genvar g = 0; g < NREAD; g++) begin : g_rbusy
        logic [ADDR_WIDTH-1:0] w_ra;
        assign w_ra     = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        // A bypassed operand is available now even if its register is busy.
        assign rbusy[g] = r_busy[w_ra] &&
                          !is_zero_reg(ZERO_REG, 32'(w_ra)) &&
                          !(BYPASS && wen && (waddr == w_ra));
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write-to-read bypass,
// optional hardwired-zero register and an integrated busy scoreboard.
//   clk, rst_n            clock, asynchronous active-low reset (clears data + busy)
//   wen, waddr, wdata     writeback port
//   raddr / rdata         packed read indices / data, port i at slice i
//   rbusy                 per-port "operand not yet available"
//   issue_valid, issue_rd reservation of a destination by decode
//   issue_ready           reservation accepted this cycle
//   flush                 clear all reservations at the next edge
//   busy_cnt              number of reserved registers
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NREAD      = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,
    input  logic                        issue_valid,
    input  logic [ADDR_WIDTH-1:0]       issue_rd,
    output logic                        issue_ready,
    input  logic                        flush,
    output logic [ADDR_WIDTH:0]         busy_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_rf [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wen && !is_zero_reg(ZERO_REG, 32'(waddr))) begin
            r_rf[waddr] <= wdata;
        end
    end

    // Zero register beats bypass, bypass beats the stored value.
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        assign w_ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
            is_zero_reg(ZERO_REG, 32'(w_ra))     ? '0    :
            (BYPASS && wen && (waddr == w_ra))   ? wdata :
                                                   r_rf[w_ra];
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NREAD      (NREAD),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .wen         (wen),
        .waddr       (waddr),
        .raddr       (raddr),
        .rbusy       (rbusy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .flush       (flush),
        .busy_cnt    (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int AW  = 5;
    localparam int DW  = 64;
    localparam int NR  = 3;
    localparam int CW  = AW + 1;
    localparam int OFS = CW + 1 + NR;
    localparam int EW  = NR*DW + NR + 1 + CW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              issue_ready;
    logic              flush;
    logic [CW-1:0]     busy_cnt;

    logic [DW-1:0]     rdata_nb;
    logic [0:0]        rbusy_nb;
    logic              issue_ready_nb;
    logic [CW-1:0]     busy_cnt_nb;

    regfile_sb #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NREAD (NR),
        .ZERO_REG (1'b1), .BYPASS (1'b1)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .wen (wen), .waddr (waddr), .wdata (wdata),
        .raddr (raddr), .rdata (rdata), .rbusy (rbusy),
        .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_ready (issue_ready),
        .flush (flush), .busy_cnt (busy_cnt)
    );

    // Same traffic, no bypass, single read port (port 0 of the main instance).
    regfile_sb #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NREAD (1),
        .ZERO_REG (1'b1), .BYPASS (1'b0)
    ) dut_nb (
        .clk (clk), .rst_n (rst_n),
        .wen (wen), .waddr (waddr), .wdata (wdata),
        .raddr (raddr[AW-1:0]), .rdata (rdata_nb), .rbusy (rbusy_nb),
        .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_ready (issue_ready_nb),
        .flush (flush), .busy_cnt (busy_cnt_nb)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic          iv;
        logic [AW-1:0] ird;
        logic          fl;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic [2:0]    erb;
        logic          eir;
        logic [CW-1:0] ecnt;
    } vec_t;

    vec_t tbl [16];
    logic [DW-1:0] m_rf [2**AW];

    function automatic vec_t mk(
        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
        input logic iv, input logic [AW-1:0] ird, input logic fl,
        input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
        input logic [2:0] erb, input logic eir, input logic [CW-1:0] ecnt);
        vec_t v;
        v.wen = w;  v.waddr = wa; v.wdata = wd;
        v.ra0 = a0; v.ra1 = a1;   v.ra2 = a2;
        v.iv = iv;  v.ird = ird;  v.fl = fl;
        v.e0 = e0;  v.e1 = e1;    v.e2 = e2;
        v.erb = erb; v.eir = eir; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(
        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
        input logic iv, input logic [AW-1:0] ird, input logic fl);
        wen = w; waddr = wa; wdata = wd;
        raddr = {a2, a1, a0};
        issue_valid = iv; issue_rd = ird; flush = fl;
    endtask

    task automatic push_exp(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [2:0] erb,
                            input logic eir, input logic [CW-1:0] ecnt);
        exp_q.push_back({e2, e1, e0, erb, eir, ecnt});
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_check(input string name);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got empty expected queue, required one entry", name);
            return;
        end
        checks--;
        e = exp_q.pop_front();
        chk({name, ".d0"},   rdata[0*DW +: DW], e[OFS + 0*DW +: DW]);
        chk({name, ".d1"},   rdata[1*DW +: DW], e[OFS + 1*DW +: DW]);
        chk({name, ".d2"},   rdata[2*DW +: DW], e[OFS + 2*DW +: DW]);
        chk({name, ".rbusy"}, DW'(rbusy),       DW'(e[CW+1 +: NR]));
        chk({name, ".ready"}, DW'(issue_ready), DW'(e[CW]));
        chk({name, ".cnt"},   DW'(busy_cnt),    DW'(e[CW-1:0]));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        //            wen wa      wdata          ra0 ra1 ra2 iv ird fl  e0             e1             e2             rb      ir cnt
        tbl[0]  = mk(0, 5'd0, 64'h0,         0,  5,  7,  0, 0, 0, 64'h0,        64'h0,        64'h0,        3'b000, 1, 0);
        tbl[1]  = mk(1, 5'd5, 64'hDEAD,      1,  5,  0,  0, 0, 0, 64'h0,        64'hDEAD,     64'h0,        3'b000, 1, 0);
        tbl[2]  = mk(0, 5'd0, 64'h0,         5,  7,  0,  0, 0, 0, 64'hDEAD,     64'h0,        64'h0,        3'b000, 1, 0);
        tbl[3]  = mk(1, 5'd7, 64'h1234,      7,  5,  7,  0, 0, 0, 64'h1234,     64'hDEAD,     64'h1234,     3'b000, 1, 0);
        tbl[4]  = mk(1, 5'd0, 64'hFFFF,      0,  0,  5,  1, 0, 0, 64'h0,        64'h0,        64'hDEAD,     3'b000, 1, 0);
        tbl[5]  = mk(0, 5'd0, 64'h0,         0,  3,  7,  0, 3, 0, 64'h0,        64'h0,        64'h1234,     3'b000, 1, 0);
        tbl[6]  = mk(0, 5'd0, 64'h0,         3,  5,  7,  1, 3, 0, 64'h0,        64'hDEAD,     64'h1234,     3'b000, 1, 0);
        tbl[7]  = mk(0, 5'd0, 64'h0,         3,  3,  5,  1, 3, 0, 64'h0,        64'h0,        64'hDEAD,     3'b011, 0, 1);
        tbl[8]  = mk(1, 5'd3, 64'hAA,        3,  5,  3,  1, 3, 0, 64'hAA,       64'hDEAD,     64'hAA,       3'b000, 1, 1);
        tbl[9]  = mk(0, 5'd0, 64'h0,         3,  0,  4,  0, 3, 0, 64'hAA,       64'h0,        64'h0,        3'b001, 0, 1);
        tbl[10] = mk(1, 5'd3, 64'hBB,        3,  3,  5,  0, 3, 0, 64'hBB,       64'hBB,       64'hDEAD,     3'b000, 1, 1);
        tbl[11] = mk(0, 5'd0, 64'h0,         1,  2,  4,  1, 1, 0, 64'h0,        64'h0,        64'h0,        3'b000, 1, 0);
        tbl[12] = mk(0, 5'd0, 64'h0,         1,  2,  3,  1, 2, 0, 64'h0,        64'h0,        64'hBB,       3'b001, 1, 1);
        tbl[13] = mk(0, 5'd0, 64'h0,         1,  2,  4,  1, 4, 0, 64'h0,        64'h0,        64'h0,        3'b011, 1, 2);
        tbl[14] = mk(1, 5'd9, 64'h99,        1,  2,  4,  1, 6, 1, 64'h0,        64'h0,        64'h0,        3'b111, 0, 3);
        tbl[15] = mk(0, 5'd0, 64'h0,         9,  2,  4,  0, 6, 0, 64'h99,       64'h0,        64'h0,        3'b000, 1, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors: outputs compared during the cycle they are driven.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].wen, tbl[i].waddr, tbl[i].wdata, tbl[i].ra0, tbl[i].ra1,
                  tbl[i].ra2, tbl[i].iv, tbl[i].ird, tbl[i].fl);
            push_exp(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].erb, tbl[i].eir, tbl[i].ecnt);
            #1;
            sb_check($sformatf("vec%0d", i));
        end

        // Bypass vs no-bypass: reserve r12, then write it back.
        @(negedge clk);
        drive(0, 0, 0, 12, 0, 0, 1, 12, 0);
        #1;
        chk("byp.reserve_ready", DW'(issue_ready), DW'(1'b1));
        @(negedge clk);
        drive(1, 12, 64'h1234, 12, 0, 0, 0, 0, 0);
        #1;
        chk("byp.main_d0",   rdata[DW-1:0], 64'h1234);
        chk("byp.main_rb0",  DW'(rbusy[0]), DW'(1'b0));
        chk("byp.main_cnt",  DW'(busy_cnt), DW'(1));
        chk("byp.nb_d0",     rdata_nb,      64'h0);
        chk("byp.nb_rb0",    DW'(rbusy_nb), DW'(1'b1));
        @(negedge clk);
        drive(0, 0, 0, 12, 0, 0, 0, 0, 0);
        #1;
        chk("byp.nb_d0_next", rdata_nb,       64'h1234);
        chk("byp.nb_rb_next", DW'(rbusy_nb),  DW'(1'b0));
        chk("byp.main_cnt0",  DW'(busy_cnt),  DW'(0));
        chk("byp.nb_cnt0",    DW'(busy_cnt_nb), DW'(0));

        // Reset in the middle of operation.
        @(negedge clk);
        drive(0, 0, 0, 5, 0, 0, 1, 20, 0);
        @(negedge clk);
        drive(0, 0, 0, 5, 0, 0, 0, 20, 0);
        #1;
        chk("rst.pre_cnt", DW'(busy_cnt), DW'(1));
        chk("rst.pre_d0",  rdata[DW-1:0], 64'hDEAD);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.d0",    rdata[DW-1:0],    64'h0);
        chk("rst.rbusy", DW'(rbusy),       DW'(3'b000));
        chk("rst.cnt",   DW'(busy_cnt),    DW'(0));
        chk("rst.ready", DW'(issue_ready), DW'(1'b1));
        chk("rst.nb_d0", rdata_nb,         64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random writes and reads against a data model (no reservations).
        for (int i = 0; i < 2**AW; i++) m_rf[i] = '0;
        for (int n = 0; n < 40; n++) begin
            logic          w;
            logic [AW-1:0] wa;
            logic [DW-1:0] wd;
            logic [AW-1:0] a [3];
            logic [DW-1:0] e [3];
            w  = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, 2**AW - 1));
            wd = {$urandom, $urandom};
            for (int p = 0; p < 3; p++) begin
                a[p] = AW'($urandom_range(0, 7));
                if (a[p] == 0)                e[p] = '0;
                else if (w && (wa == a[p]))   e[p] = wd;
                else                          e[p] = m_rf[a[p]];
            end
            @(negedge clk);
            drive(w, wa, wd, a[0], a[1], a[2], 0, 0, 0);
            push_exp(e[0], e[1], e[2], 3'b000, 1'b1, '0);
            #1;
            sb_check($sformatf("rnd%0d", n));
            if (w && (wa != 0)) m_rf[wa] = wd;
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
